// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code set 2 constants and decoder state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;

  // Device responses and the pause sequence lead-in; never key events.
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_E0   = 2'd1,
    ST_F0   = 2'd2,
    ST_E0F0 = 2'd3
  } ps2_state_t;

  function automatic logic is_non_key(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT_OK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_PAUSE);
  endfunction

endpackage

// File: rtl/ps2_byte_history.sv
// Shift-register history of received bytes (slice 0 newest) with a
// saturating fill count.
module ps2_byte_history #(
  parameter int DEPTH = 4
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         shift_en,
  input  logic [7:0]                   shift_data,
  output logic [8*DEPTH-1:0]           hist_data,
  output logic [$clog2(DEPTH+1)-1:0]   hist_count
);

  localparam int CW = $clog2(DEPTH + 1);

  // Shift each new byte in at slice 0; clear wins over a same-cycle byte.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hist_data  <= '0;
      hist_count <= '0;
    end else if (clear) begin
      hist_data  <= '0;
      hist_count <= '0;
    end else if (shift_en) begin
      hist_data[7:0] <= shift_data;
      for (int i = 1; i < DEPTH; i++)
        hist_data[8*i +: 8] <= hist_data[8*(i-1) +: 8];
      if (hist_count != CW'(DEPTH))
        hist_count <= hist_count + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set 2 make/break decoder with per-key held state, press/release
// pulses, a decoded event stream and a byte history.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | no prefix pending; next key byte is a plain make
// E0      | extended prefix seen; next key byte is an ext make
// F0      | break prefix seen; next byte is a plain break
// E0F0    | extended break prefix seen; next byte is an ext break
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int                  NUM_KEYS       = 4,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES    = {8'h23, 8'h1B, 8'h1C, 8'h1D},
  parameter logic [NUM_KEYS-1:0] KEY_EXT        = '0,
  parameter int                  HIST_DEPTH     = 4,
  parameter int                  TIMEOUT_CYCLES = 2500000
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic                            clear,
  input  logic [7:0]                      ps2_data,
  input  logic                            ps2_data_en,
  output logic [NUM_KEYS-1:0]             key_down,
  output logic [NUM_KEYS-1:0]             key_press,
  output logic [NUM_KEYS-1:0]             key_release,
  output logic                            event_valid,
  output logic [7:0]                      event_code,
  output logic                            event_ext,
  output logic                            event_break,
  output logic [8*HIST_DEPTH-1:0]         hist_data,
  output logic [$clog2(HIST_DEPTH+1)-1:0] hist_count
);

  // Prefix timeout runs as a down-counter: loaded on each prefix byte,
  // abandons the prefix when it sits at zero with no byte arriving.
  localparam int              TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_t          state, state_nxt;
  logic [TW-1:0]       tmr, tmr_nxt;
  logic                ev_fire, ev_ext_nxt, ev_brk_nxt;
  logic [NUM_KEYS-1:0] key_match;

  // State and timeout counter registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else if (clear) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Next-state decode, event detection and timeout countdown.
  always_comb begin
    state_nxt  = state;
    tmr_nxt    = tmr;
    ev_fire    = 1'b0;
    ev_ext_nxt = 1'b0;
    ev_brk_nxt = 1'b0;
    if (ps2_data_en) begin
      case (state)
        ST_IDLE: begin
          if (ps2_data == PS2_PREFIX_EXT)        state_nxt = ST_E0;
          else if (ps2_data == PS2_PREFIX_BREAK) state_nxt = ST_F0;
          else if (!is_non_key(ps2_data))        ev_fire   = 1'b1;
        end
        ST_E0: begin
          if (ps2_data == PS2_PREFIX_BREAK) state_nxt = ST_E0F0;
          else if (ps2_data != PS2_PREFIX_EXT) begin
            ev_fire    = 1'b1;
            ev_ext_nxt = 1'b1;
            state_nxt  = ST_IDLE;
          end
        end
        ST_F0: begin
          ev_fire    = 1'b1;
          ev_brk_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
        default: begin
          ev_fire    = 1'b1;
          ev_ext_nxt = 1'b1;
          ev_brk_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      endcase
      tmr_nxt = (state_nxt == ST_IDLE) ? '0 : TMR_LOAD;
    end else if (state != ST_IDLE) begin
      if (tmr == '0) state_nxt = ST_IDLE;
      else           tmr_nxt   = tmr - 1'b1;
    end else begin
      tmr_nxt = '0;
    end
  end

  // Keys whose code and prefix both match the event being decoded.
  always_comb begin
    key_match = '0;
    for (int i = 0; i < NUM_KEYS; i++)
      key_match[i] = ev_fire && (ps2_data == KEY_CODES[8*i +: 8]) &&
                     (ev_ext_nxt == KEY_EXT[i]);
  end

  // Event stream: valid pulses, code/ext/break hold until the next event.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      event_valid <= 1'b0;
      event_code  <= '0;
      event_ext   <= 1'b0;
      event_break <= 1'b0;
    end else if (clear) begin
      event_valid <= 1'b0;
      event_code  <= '0;
      event_ext   <= 1'b0;
      event_break <= 1'b0;
    end else begin
      event_valid <= ev_fire;
      if (ev_fire) begin
        event_code  <= ps2_data;
        event_ext   <= ev_ext_nxt;
        event_break <= ev_brk_nxt;
      end
    end
  end

  // Held state per key; edges only on real transitions so typematic is silent.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_down    <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else if (clear) begin
      key_down    <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_match[i]) begin
          if (ev_brk_nxt) begin
            key_down[i]    <= 1'b0;
            key_release[i] <= key_down[i];
          end else begin
            key_down[i]  <= 1'b1;
            key_press[i] <= !key_down[i];
          end
        end
      end
    end
  end

  ps2_byte_history #(
    .DEPTH(HIST_DEPTH)
  ) u_hist (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .clear     (clear),
    .shift_en  (ps2_data_en),
    .shift_data(ps2_data),
    .hist_data (hist_data),
    .hist_count(hist_count)
  );

endmodule
